// File: rtl/router_pkg.sv
// Shared defaults and width helper for the router synchroniser slice.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_TIMEOUT = 30;

  // Width that can hold the values 0..n-1, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall watchdog: flushes an output FIFO that is left unread for
// TIMEOUT consecutive cycles, and records the event in a sticky status bit.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic read_enb,
  input  logic sts_clr,
  output logic soft_reset,
  output logic timeout_sts
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;
  logic             fire;

  assign stall = vld & ~read_enb;
  assign fire  = stall && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      soft_reset  <= 1'b0;
      timeout_sts <= 1'b0;
    end else begin
      soft_reset  <= fire;
      // A new timeout beats a simultaneous clear so no event is ever lost.
      timeout_sts <= fire | (timeout_sts & ~sts_clr);
      if (!stall || fire) cnt <= '0;
      else                cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Synchroniser between the router FSM and NUM_CH output FIFOs: address latch,
// write-enable decode, full-flag mux and per-channel stall watchdogs.
module router_sync_n
  import router_pkg::*;
#(
  parameter  int NUM_CH  = ROUTER_NUM_CH,
  parameter  int TIMEOUT = ROUTER_TIMEOUT,
  localparam int ADDR_W  = clog2w(NUM_CH),
  localparam int CNT_W   = clog2w(TIMEOUT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] sts_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_sts
);

  // One extra bit so NUM_CH itself is representable when NUM_CH is 2**ADDR_W.
  localparam logic [ADDR_W:0] NUM_CH_V = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_ok;
  logic              legal;
  logic [NUM_CH-1:0] sel;

  assign legal = ({1'b0, data_in} < NUM_CH_V);

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      addr_ok  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= detect_add & ~legal;
      if (detect_add) begin
        addr_q  <= data_in;
        addr_ok <= legal;
      end
    end
  end

  // An illegal address selects nothing: the packet is dropped and never stalls.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      sel[i] = addr_ok && (addr_q == ADDR_W'(i));
  end

  assign write_enb = write_enb_reg ? sel : '0;
  assign fifo_full = |(full & sel);
  assign vld_out   = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock       (clock),
      .reset       (reset),
      .vld         (vld_out[g]),
      .read_enb    (read_enb[g]),
      .sts_clr     (sts_clr[g]),
      .soft_reset  (soft_reset[g]),
      .timeout_sts (timeout_sts[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: directed scenarios plus a randomized run against a
// run-length reference model; a second 8-channel instance covers the wide sweep.
module tb_router_sync_n;

  localparam int NCH = 3;
  localparam int TMO = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] empty, full, read_enb, sts_clr;
  logic [2:0] write_enb, vld_out, soft_reset, timeout_sts;
  logic       fifo_full, addr_err;

  logic       d8_det, d8_wer, d8_ff, d8_err;
  logic [2:0] d8_data;
  logic [7:0] d8_empty, d8_full, d8_rd, d8_clr;
  logic [7:0] d8_we, d8_vld, d8_sr, d8_sts;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_addr;
  logic       m_ok, m_err;
  logic [2:0] m_sr, m_sts;
  int         m_run[3];

  always #5 clock = ~clock;

  router_sync_n #(.NUM_CH(NCH), .TIMEOUT(TMO)) u_dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .empty(empty), .full(full),
    .read_enb(read_enb), .sts_clr(sts_clr), .write_enb(write_enb),
    .fifo_full(fifo_full), .vld_out(vld_out), .soft_reset(soft_reset),
    .addr_err(addr_err), .timeout_sts(timeout_sts)
  );

  router_sync_n #(.NUM_CH(8), .TIMEOUT(4)) u_dut8 (
    .clock(clock), .reset(reset), .detect_add(d8_det), .data_in(d8_data),
    .write_enb_reg(d8_wer), .empty(d8_empty), .full(d8_full),
    .read_enb(d8_rd), .sts_clr(d8_clr), .write_enb(d8_we),
    .fifo_full(d8_ff), .vld_out(d8_vld), .soft_reset(d8_sr),
    .addr_err(d8_err), .timeout_sts(d8_sts)
  );

  // One clock edge; the model advances from the inputs present at that edge.
  // A channel's soft reset fires whenever its unbroken stall run hits a multiple of TMO.
  task automatic tick();
    int         n_addr, n_run[3];
    logic       n_ok, n_err;
    logic [2:0] n_sr, n_sts;
    n_addr = m_addr; n_ok = m_ok; n_err = 1'b0; n_sr = '0; n_sts = m_sts;
    for (int i = 0; i < NCH; i++) n_run[i] = m_run[i];
    if (reset) begin
      n_addr = 0; n_ok = 1'b0; n_sts = '0;
      for (int i = 0; i < NCH; i++) n_run[i] = 0;
    end else begin
      if (detect_add) begin
        n_addr = int'(data_in);
        n_ok   = (n_addr < NCH);
        n_err  = !n_ok;
      end
      for (int i = 0; i < NCH; i++) begin
        if (!empty[i] && !read_enb[i]) begin
          n_run[i] = m_run[i] + 1;
          n_sr[i]  = (n_run[i] % TMO == 0);
        end else begin
          n_run[i] = 0;
        end
        n_sts[i] = n_sr[i] | (m_sts[i] & !sts_clr[i]);
      end
    end
    @(posedge clock);
    #1;
    m_addr = n_addr; m_ok = n_ok; m_err = n_err; m_sr = n_sr; m_sts = n_sts;
    for (int i = 0; i < NCH; i++) m_run[i] = n_run[i];
  endtask

  task automatic test_reset();
    reset = 1'b1; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b1;
    empty = '1; full = '0; read_enb = '0; sts_clr = '0;
    d8_det = 1'b0; d8_data = '0; d8_wer = 1'b0; d8_empty = '1; d8_full = '0;
    d8_rd = '0; d8_clr = '0;
    tick();
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL rst_we got=%b exp=000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_ff got=%b exp=0", fifo_full); end
    checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL rst_vld got=%b exp=000", vld_out); end
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL rst_sr got=%b exp=000", soft_reset); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", addr_err); end
    checks++; if (timeout_sts !== 3'b000) begin errors++; $display("FAIL rst_sts got=%b exp=000", timeout_sts); end
    empty = 3'b101;
    #1;
    checks++; if (vld_out !== 3'b010) begin errors++; $display("FAIL rst_vld_comb got=%b exp=010", vld_out); end
    empty = '1; reset = 1'b0; write_enb_reg = 1'b0;
    tick();
  endtask

  task automatic test_route();
    detect_add = 1'b1; data_in = 2'd1;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    #1;
    checks++; if (write_enb !== 3'b010) begin errors++; $display("FAIL route_we got=%b exp=010", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL route_ff0 got=%b exp=0", fifo_full); end
    full = 3'b010;
    #1;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL route_ff1 got=%b exp=1", fifo_full); end
    full = 3'b001;
    #1;
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL route_ff_other got=%b exp=0", fifo_full); end
    // New address captured on the same cycle as a write still uses the old one.
    detect_add = 1'b1; data_in = 2'd2;
    #1;
    checks++; if (write_enb !== 3'b010) begin errors++; $display("FAIL route_old_addr got=%b exp=010", write_enb); end
    tick();
    detect_add = 1'b0;
    #1;
    checks++; if (write_enb !== 3'b100) begin errors++; $display("FAIL route_new_addr got=%b exp=100", write_enb); end
    write_enb_reg = 1'b0; full = '0;
    tick();
  endtask

  task automatic test_illegal();
    detect_add = 1'b1; data_in = 2'd3;
    tick();
    detect_add = 1'b0;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ill_err_hi got=%b exp=1", addr_err); end
    write_enb_reg = 1'b1; full = 3'b111;
    tick();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL ill_err_lo got=%b exp=0", addr_err); end
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL ill_we got=%b exp=000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ill_ff got=%b exp=0", fifo_full); end
    write_enb_reg = 1'b0; full = '0;
  endtask

  task automatic test_timeout();
    empty = 3'b101; read_enb = '0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      checks++;
      if (soft_reset !== ((c == 30 || c == 60) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL to_pulse cyc=%0d got=%b", c, soft_reset);
      end
    end
    checks++; if (timeout_sts !== 3'b010) begin errors++; $display("FAIL to_sts got=%b exp=010", timeout_sts); end
    read_enb = 3'b010;
    tick();
    for (int c = 1; c <= 60; c++) begin
      read_enb = (c == 29) ? 3'b010 : 3'b000;
      tick();
      checks++;
      if (soft_reset[1] !== (c == 59)) begin
        errors++; $display("FAIL to_break cyc=%0d got=%b exp=%b", c, soft_reset[1], (c == 59));
      end
    end
  endtask

  task automatic test_sts_clr();
    read_enb = 3'b010; sts_clr = 3'b010;
    tick();
    checks++; if (timeout_sts[1] !== 1'b0) begin errors++; $display("FAIL clr_plain got=%b exp=0", timeout_sts[1]); end
    read_enb = '0; sts_clr = '0;
    repeat (29) tick();
    sts_clr = 3'b010;
    tick();
    checks++; if (soft_reset[1] !== 1'b1) begin errors++; $display("FAIL clr_pulse got=%b exp=1", soft_reset[1]); end
    checks++; if (timeout_sts[1] !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", timeout_sts[1]); end
    tick();
    checks++; if (timeout_sts[1] !== 1'b0) begin errors++; $display("FAIL clr_after got=%b exp=0", timeout_sts[1]); end
    sts_clr = '0;
  endtask

  task automatic test_reset_mid();
    detect_add = 1'b1; data_in = 2'd0; read_enb = 3'b010;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; read_enb = '0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL rmid_sr got=%b exp=000", soft_reset); end
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL rmid_we got=%b exp=000", write_enb); end
    checks++; if (timeout_sts !== 3'b000) begin errors++; $display("FAIL rmid_sts got=%b exp=000", timeout_sts); end
    reset = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      checks++;
      if (soft_reset[1] !== (c == 30)) begin
        errors++; $display("FAIL rmid_restart cyc=%0d got=%b exp=%b", c, soft_reset[1], (c == 30));
      end
    end
    write_enb_reg = 1'b0;
  endtask

  task automatic test_route8();
    for (int a = 0; a < 8; a++) begin
      logic [7:0] exp_we;
      d8_data = 3'(a); d8_det = 1'b1; d8_wer = 1'b0;
      tick();
      d8_det = 1'b0; d8_wer = 1'b1; d8_full = 8'($urandom);
      #1;
      exp_we = 8'b1 << a;
      checks++; if (d8_err !== 1'b0) begin errors++; $display("FAIL r8_err a=%0d got=%b", a, d8_err); end
      checks++; if (d8_we !== exp_we) begin errors++; $display("FAIL r8_we a=%0d got=%b exp=%b", a, d8_we, exp_we); end
      checks++; if (d8_ff !== d8_full[a]) begin errors++; $display("FAIL r8_ff a=%0d got=%b exp=%b", a, d8_ff, d8_full[a]); end
    end
    checks++; if (d8_sr !== 8'h00) begin errors++; $display("FAIL r8_sr got=%b exp=0", d8_sr); end
    d8_wer = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] e_we;
    logic       e_ff;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset         = ($urandom_range(299) == 0);
      detect_add    = ($urandom_range(7) == 0);
      data_in       = 2'($urandom_range(3));
      write_enb_reg = 1'($urandom);
      full          = 3'($urandom);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(63) == 0) empty[i] = ~empty[i];
        read_enb[i] = ($urandom_range(49) == 0);
        sts_clr[i]  = ($urandom_range(9) == 0);
      end
      #1;
      e_we = '0;
      if (write_enb_reg && m_ok) e_we[m_addr] = 1'b1;
      e_ff = m_ok ? full[m_addr] : 1'b0;
      checks++; if (write_enb !== e_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, write_enb, e_we); end
      checks++; if (fifo_full !== e_ff) begin errors++; $display("FAIL rnd_ff cyc=%0d got=%b exp=%b", cyc, fifo_full, e_ff); end
      checks++; if (vld_out !== ~empty) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, vld_out, ~empty); end
      checks++; if (soft_reset !== m_sr) begin errors++; $display("FAIL rnd_sr cyc=%0d got=%b exp=%b", cyc, soft_reset, m_sr); end
      checks++; if (addr_err !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, addr_err, m_err); end
      checks++; if (timeout_sts !== m_sts) begin errors++; $display("FAIL rnd_sts cyc=%0d got=%b exp=%b", cyc, timeout_sts, m_sts); end
      tick();
    end
  endtask

  initial begin
    m_addr = 0; m_ok = 1'b0; m_err = 1'b0; m_sr = '0; m_sts = '0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    test_reset();
    test_route();
    test_illegal();
    test_timeout();
    test_sts_clr();
    test_reset_mid();
    test_route8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised synchroniser between the router FSM and its N output FIFOs. It latches the destination address of each packet, routes write enables to one FIFO, and muxes that FIFO's full flag back to the FSM. It also drives per-channel valid outputs and per-channel soft resets when an output is left unread too long. It generalises the fixed 1x3 synchroniser with these additions:
- configurable channel count and timeout
- illegal-address detection
- sticky timeout status

## Interface
Parameters:
- NUM_CH, 3, number of output channels, 2..16
- TIMEOUT, 30, consecutive stalled cycles before soft reset, ≥2
- ADDR_W, derived localparam = max(1,$clog2(NUM_CH)), address width
- CNT_W, derived localparam = $clog2(TIMEOUT), timer width

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- detect_add  in  1  header cycle strobe from FSM; capture data_in
- data_in  in  ADDR_W  destination address
- write_enb_reg  in  1  FSM write request for current packet
- empty  in  NUM_CH  per-FIFO empty
- full  in  NUM_CH  per-FIFO full
- read_enb  in  NUM_CH  per-channel downstream read enable
- sts_clr  in  NUM_CH  clear request for timeout_sts bits
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of addressed FIFO
- vld_out  out  NUM_CH  per-channel data valid
- soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse
- addr_err  out  1  one-cycle pulse: captured address ≥ NUM_CH
- timeout_sts  out  NUM_CH  sticky: channel has timed out

## Operation
- Address register addr_q/addr_ok:
  - On detect_add=1, addr_q←data_in and addr_ok←(data_in<NUM_CH).
  - Otherwise addr_q and addr_ok hold.
- addr_err: registered; high for exactly the one cycle after a detect_add edge that captured an illegal address.
- write_enb:
  - Combinational: bit addr_q set iff write_enb_reg && addr_ok; all other bits 0.
  - With illegal address, no bit is set, so the packet is dropped.
- fifo_full:
  - Combinational = full[addr_q] when addr_ok, else 0.
  - With an illegal address, the FSM never stalls.
- vld_out[i]: combinational = ~empty[i]; independent of reset.
- Per-channel timer cnt[i], stall condition = vld_out[i] && !read_enb[i]:
  - Stall true and cnt ≠ TIMEOUT−1: cnt++, soft_reset[i]←0.
  - Stall true and cnt = TIMEOUT−1: cnt←0, soft_reset[i]←1.
  - Stall false: cnt←0, soft_reset[i]←0.
- timeout_sts[i]:
  - Set when soft_reset[i] is being registered high.
  - Cleared by sts_clr[i].
  - Set wins on the same edge.
- Channels are fully independent; several soft_reset bits may pulse on the same cycle.

## Timing
- Reset values, after first edge with reset=1: addr_q=0, addr_ok=0, cnt=0, soft_reset=0, addr_err=0, timeout_sts=0.
  - Consequently write_enb=0 and fifo_full=0.
  - vld_out follows empty.
- Address latency:
  - detect_add sampled at edge k; the new address steers write_enb/fifo_full from cycle k+1.
  - detect_add and write_enb_reg high together in cycle k: write_enb uses the old addr_q in cycle k.
- Timeout latency:
  - Stall first sampled at edge k and true at edges k..k+TIMEOUT−1: soft_reset high during cycle after edge k+TIMEOUT−1, for one cycle.
  - Persisting stall re-pulses every TIMEOUT cycles.
  - Any single non-stall cycle restarts the count from 0.
- Reset mid-stall discards partial counts; a soft_reset pulse in flight is cut to zero at the reset edge.
- Reset mid-packet drops write_enb from the next cycle, because addr_ok clears.
- No combinational path from reset to outputs.

## Structure
- Shared package router_pkg: ROUTER_NUM_CH=3, ROUTER_TIMEOUT=30 defaults, and a clog2-based width helper function used for ADDR_W/CNT_W.
- Sub-module router_sync_timer (params TIMEOUT, CNT_W; ports clock, reset, vld, read_enb, sts_clr, soft_reset, timeout_sts), instantiated NUM_CH times in a generate loop.
- Address register, decode and full mux live in the top.

## Test plan
- Reset with empty=all 1, full=0 → all outputs 0 and vld_out=0. Then empty[1]=0 → vld_out=3'b010 in the same cycle.
- NUM_CH=3: detect_add with data_in=1, then write_enb_reg=1 → write_enb=3'b010. Then full[1]=1 → fifo_full=1 with no cycle delay. full[0]=1 alone → fifo_full=0.
- NUM_CH=3, ADDR_W=2: data_in=3 → addr_err high exactly one cycle. A following write_enb_reg=1 → write_enb=0 and fifo_full=0 even with full=3'b111.
- TIMEOUT=30, empty[1]=0, read_enb[1]=0 held → soft_reset[1] pulses on cycle 30, again on cycle 60, and timeout_sts[1]=1. read_enb[1]=1 for one cycle at cycle 29 → no pulse until cycle 59.
- sts_clr[1]=1 on the same edge as a new soft_reset[1] → timeout_sts[1] stays 1. sts_clr[1] with no event → clears to 0.
- reset asserted at stall cycle 20 → soft_reset stays 0, the count restarts, and the first pulse occurs 30 cycles after reset deasserts. NUM_CH=8 regression repeats the routing sweep over all addresses.
